// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port between
// the in-order W stage (priority) and a FIFO of multi-cycle unit results.
// Tracks outstanding MDU destinations and forces a one-cycle pipeline stall
// when the FIFO head has been blocked for STARVE_MAX cycles.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  input  logic              PIPE_WE_i,
  input  logic [4:0]        PIPE_RD_i,
  input  logic [DATA_W-1:0] PIPE_DATA_i,
  input  logic              MDU_VALID_i,
  output logic              MDU_READY_o,
  input  logic [4:0]        MDU_RD_i,
  input  logic [DATA_W-1:0] MDU_DATA_i,
  input  logic              MDU_ISSUE_i,
  input  logic [4:0]        MDU_ISSUE_RD_i,
  output logic              RF_WE_o,
  output logic [4:0]        RF_RD_o,
  output logic [DATA_W-1:0] RF_DATA_o,
  output logic [31:0]       PEND_o,
  output logic              STALL_o,
  output logic              ERR_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // FIFO storage and pointers (extra pointer bit distinguishes full from empty)
  logic [4:0]        r_fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;

  // Pipeline write parked during a starve cycle
  logic              r_hold_vld;
  logic [4:0]        r_hold_rd;
  logic [DATA_W-1:0] r_hold_data;

  logic [SW-1:0]     r_starve;
  logic              r_rf_we;
  logic [4:0]        r_rf_rd;
  logic [DATA_W-1:0] r_rf_data;
  logic [31:0]       r_pend;
  logic              r_err;

  logic [PW-1:0]     w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_store;
  logic              w_pipe_vld;
  logic              w_starve;
  logic [4:0]        w_head_rd;
  logic [DATA_W-1:0] w_head_data;
  logic              w_we;
  logic [4:0]        w_rd;
  logic [DATA_W-1:0] w_data;
  logic              w_pop;
  logic              w_hold_set;
  logic              w_stall;
  logic              w_err_set;
  logic [31:0]       w_set_mask;
  logic [31:0]       w_clr_mask;

  assign w_count     = r_wptr - r_rptr;
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (w_count == PW'(FIFO_DEPTH));
  // rd=0 results are acknowledged but never occupy a slot
  assign w_store     = MDU_VALID_i && !w_full && (MDU_RD_i != 5'd0);
  assign w_pipe_vld  = PIPE_WE_i && (PIPE_RD_i != 5'd0);
  assign w_starve    = !w_empty && (r_starve == SW'(STARVE_MAX));
  assign w_head_rd   = r_fifo_rd[r_rptr[AW-1:0]];
  assign w_head_data = r_fifo_data[r_rptr[AW-1:0]];

  // Write-port grant: HOLD, then starved FIFO head, then pipeline, then FIFO
  always_comb begin
    w_we       = 1'b0;
    w_rd       = r_rf_rd;
    w_data     = r_rf_data;
    w_pop      = 1'b0;
    w_hold_set = 1'b0;
    w_stall    = 1'b0;
    w_err_set  = 1'b0;
    if (r_hold_vld) begin
      w_we      = 1'b1;
      w_rd      = r_hold_rd;
      w_data    = r_hold_data;
      // A new pipeline write now has nowhere to go; it is dropped and flagged
      w_err_set = w_pipe_vld;
    end else if (w_starve) begin
      w_we       = 1'b1;
      w_rd       = w_head_rd;
      w_data     = w_head_data;
      w_pop      = 1'b1;
      w_stall    = 1'b1;
      w_hold_set = w_pipe_vld;
    end else if (w_pipe_vld) begin
      w_we   = 1'b1;
      w_rd   = PIPE_RD_i;
      w_data = PIPE_DATA_i;
    end else if (!w_empty) begin
      w_we   = 1'b1;
      w_rd   = w_head_rd;
      w_data = w_head_data;
      w_pop  = 1'b1;
    end else begin
      w_we = 1'b0;
    end
  end

  // Scoreboard masks: issue sets, FIFO-sourced write clears; set wins on overlap
  always_comb begin
    w_set_mask = 32'd0;
    w_clr_mask = 32'd0;
    if (MDU_ISSUE_i && (MDU_ISSUE_RD_i != 5'd0)) begin
      w_set_mask = 32'd1 << MDU_ISSUE_RD_i;
    end else begin
      w_set_mask = 32'd0;
    end
    if (w_pop) begin
      w_clr_mask = 32'd1 << w_head_rd;
    end else begin
      w_clr_mask = 32'd0;
    end
  end

  // FIFO payload storage; contents are don't-care until the pointers cover them
  always_ff @(posedge CLK_i) begin
    if (w_store) begin
      r_fifo_rd[r_wptr[AW-1:0]]   <= MDU_RD_i;
      r_fifo_data[r_wptr[AW-1:0]] <= MDU_DATA_i;
    end
  end

  // Control state: pointers, HOLD, starve counter, registered outputs
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_hold_vld  <= 1'b0;
      r_hold_rd   <= 5'd0;
      r_hold_data <= '0;
      r_starve    <= '0;
      r_rf_we     <= 1'b0;
      r_rf_rd     <= 5'd0;
      r_rf_data   <= '0;
      r_pend      <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      if (w_store) r_wptr <= r_wptr + PW'(1);
      if (w_pop)   r_rptr <= r_rptr + PW'(1);
      r_hold_vld <= w_hold_set;
      if (w_hold_set) begin
        r_hold_rd   <= PIPE_RD_i;
        r_hold_data <= PIPE_DATA_i;
      end
      if (w_pop || w_empty) begin
        r_starve <= '0;
      end else if (r_starve != SW'(STARVE_MAX)) begin
        r_starve <= r_starve + SW'(1);
      end
      r_rf_we   <= w_we;
      r_rf_rd   <= w_rd;
      r_rf_data <= w_data;
      r_pend    <= (r_pend & ~w_clr_mask) | w_set_mask;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign MDU_READY_o = !w_full;
  assign STALL_o     = w_stall;
  assign RF_WE_o     = r_rf_we;
  assign RF_RD_o     = r_rf_rd;
  assign RF_DATA_o   = r_rf_data;
  assign PEND_o      = r_pend;
  assign ERR_o       = r_err;

endmodule
